// File: rtl/ram_sdp_init_if.sv
// Client bus of the simple-dual-port RAM with init sequencer.
// The master drives requests; the slave (the RAM) returns status and read data.
interface ram_sdp_init_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 7
);
  logic              init_req;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] q;
  logic              rd_valid;
  logic              err;

  modport master (
    output init_req, wr_en, wr_addr, data, rd_en, rd_addr,
    input  busy, q, rd_valid, err
  );

  modport slave (
    input  init_req, wr_en, wr_addr, data, rd_en, rd_addr,
    output busy, q, rd_valid, err
  );
endinterface

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with registered, write-first read and a hardware
// sweep that fills every word with INIT_VAL after reset or on request.
// The array itself has no reset; its content is defined once a sweep ends.
module ram_sdp_init #(
  parameter int              DATA_W   = 9,
  parameter int              ADDR_W   = 7,
  parameter int              DEPTH    = 128,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic          clk,
  input logic          rst_n,
  ram_sdp_init_if.slave bus
);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] q;
  logic              rd_valid;
  logic              err;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign idle  = (state == ST_IDLE);
  assign wr_ok = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_ok = ({1'b0, bus.rd_addr} < DEPTH_W);

  // Single write port: the sweep owns it while busy, the user otherwise.
  always_comb begin
    mem_we    = 1'b1;
    mem_waddr = ptr;
    mem_wdata = INIT_VAL;
    if (idle) begin
      mem_we    = bus.wr_en & wr_ok;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.data;
    end
  end

  // Array write, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Sequencer FSM plus registered read data and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      ptr      <= '0;
      q        <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_INIT: begin
          // User accesses are dropped while the sweep runs.
          err <= bus.wr_en | bus.rd_en;
          if (ptr == LAST_PTR) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          if (bus.wr_en && !wr_ok) begin
            err <= 1'b1;
          end
          if (bus.rd_en) begin
            rd_valid <= 1'b1;
            if (!rd_ok) begin
              q   <= '0;
              err <= 1'b1;
            end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
              // Write-first: a same-cycle write to the read address wins.
              q <= bus.data;
            end else begin
              q <= mem[bus.rd_addr];
            end
          end
          // Accesses of this cycle still complete before the new sweep.
          if (bus.init_req) begin
            state <= ST_INIT;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.busy     = (state == ST_INIT);
  assign bus.q        = q;
  assign bus.rd_valid = rd_valid;
  assign bus.err      = err;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init: a 128-word instance checked with directed tables,
// hand sequences and random traffic against a behavioural model, plus a
// 100-word instance for out-of-range accesses.
module tb_ram_sdp_init;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_sdp_init_if #(.DATA_W(9), .ADDR_W(7)) bus_a ();
  ram_sdp_init_if #(.DATA_W(9), .ADDR_W(7)) bus_b ();

  ram_sdp_init #(.DATA_W(9), .ADDR_W(7), .DEPTH(128), .INIT_VAL(9'h1FF)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  ram_sdp_init #(.DATA_W(9), .ADDR_W(7), .DEPTH(100), .INIT_VAL(9'h1FF)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of the 128-word instance.
  int         init_left;
  logic [8:0] m_mem [128];
  logic [8:0] m_q;
  logic       m_valid;
  logic       m_err;

  typedef struct {
    logic       we;
    logic [6:0] wa;
    logic [8:0] d;
    logic       re;
    logic [6:0] ra;
    logic [8:0] eq;
    logic       ev;
    logic       ee;
    logic       eb;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    init_left = 128;
    m_q       = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
  endtask

  // One clock of the model, from the rules: a sweep lasts 128 cycles and
  // leaves every word at 1FF; idle writes land before same-cycle reads.
  task automatic model_step(input logic ireq, input logic we, input logic [6:0] wa,
                            input logic [8:0] d, input logic re, input logic [6:0] ra);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (init_left > 0) begin
      m_err = we | re;
      init_left--;
      if (init_left == 0) begin
        for (int i = 0; i < 128; i++) m_mem[i] = 9'h1FF;
      end
    end else begin
      if (we) m_mem[wa] = d;
      if (re) begin
        m_valid = 1'b1;
        m_q     = m_mem[ra];
      end
      if (ireq) init_left = 128;
    end
  endtask

  // Drive one cycle on instance A, advance the model, sample after the edge.
  task automatic cyc(input logic ireq, input logic we, input logic [6:0] wa,
                     input logic [8:0] d, input logic re, input logic [6:0] ra);
    bus_a.init_req = ireq;
    bus_a.wr_en    = we;
    bus_a.wr_addr  = wa;
    bus_a.data     = d;
    bus_a.rd_en    = re;
    bus_a.rd_addr  = ra;
    model_step(ireq, we, wa, d, re, ra);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 7'h00, 9'h000, 1'b0, 7'h00);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".q"}, 32'(bus_a.q), 32'(m_q));
    chk({tag, ".rd_valid"}, 32'(bus_a.rd_valid), 32'(m_valid));
    chk({tag, ".err"}, 32'(bus_a.err), 32'(m_err));
    chk({tag, ".busy"}, 32'(bus_a.busy), 32'(init_left > 0));
  endtask

  task automatic b_drive(input logic we, input logic [6:0] wa, input logic [8:0] d,
                         input logic re, input logic [6:0] ra);
    bus_b.init_req = 1'b0;
    bus_b.wr_en    = we;
    bus_b.wr_addr  = wa;
    bus_b.data     = d;
    bus_b.rd_en    = re;
    bus_b.rd_addr  = ra;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nb;
    logic [6:0] wa;
    logic [6:0] ra;
    logic [8:0] d;
    logic [6:0] rd_list [$];

    tbl[0] = '{we:0, wa:7'h00, d:9'h000, re:1, ra:7'h00, eq:9'h1FF, ev:1, ee:0, eb:0};
    tbl[1] = '{we:0, wa:7'h00, d:9'h000, re:1, ra:7'h13, eq:9'h1FF, ev:1, ee:0, eb:0};
    tbl[2] = '{we:0, wa:7'h00, d:9'h000, re:1, ra:7'h7F, eq:9'h1FF, ev:1, ee:0, eb:0};
    tbl[3] = '{we:1, wa:7'h00, d:9'h048, re:0, ra:7'h00, eq:9'h1FF, ev:0, ee:0, eb:0};
    tbl[4] = '{we:1, wa:7'h01, d:9'h001, re:1, ra:7'h00, eq:9'h048, ev:1, ee:0, eb:0};
    tbl[5] = '{we:0, wa:7'h00, d:9'h000, re:1, ra:7'h01, eq:9'h001, ev:1, ee:0, eb:0};
    tbl[6] = '{we:1, wa:7'h05, d:9'h153, re:1, ra:7'h05, eq:9'h153, ev:1, ee:0, eb:0};
    tbl[7] = '{we:0, wa:7'h00, d:9'h000, re:0, ra:7'h00, eq:9'h153, ev:0, ee:0, eb:0};
    tbl[8] = '{we:0, wa:7'h00, d:9'h000, re:1, ra:7'h05, eq:9'h153, ev:1, ee:0, eb:0};

    bus_a.init_req = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.data = '0;
    bus_a.rd_en = 1'b0; bus_a.rd_addr = '0;
    b_drive(1'b0, 7'h00, 9'h000, 1'b0, 7'h00);
    bus_b.init_req = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(bus_a.busy), 32'd1);
    chk("rst.q", 32'(bus_a.q), 32'd0);
    chk("rst.rd_valid", 32'(bus_a.rd_valid), 32'd0);
    chk("rst.err", 32'(bus_a.err), 32'd0);

    // Test 1: sweep length on both instances.
    @(negedge clk);
    rst_n = 1'b1;
    n  = 0;
    nb = 0;
    while (n < 400) begin
      idle_cyc();
      n++;
      if (nb == 0 && !bus_b.busy) nb = n;
      if (!bus_a.busy) break;
    end
    $display("init sweep: busy_a low after %0d edges, busy_b low after %0d edges", n, nb);
    chk("init_len_128", 32'(n), 32'd128);
    chk("init_len_100", 32'(nb), 32'd100);

    // Directed table: init content, write/read, collision, hold of q.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].re, tbl[i].ra);
      $display("vec %0d: we=%0d wa=%h d=%h re=%0d ra=%h -> q=%h v=%0d e=%0d b=%0d",
               i, tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].re, tbl[i].ra,
               bus_a.q, bus_a.rd_valid, bus_a.err, bus_a.busy);
      chk($sformatf("vec%0d.q", i), 32'(bus_a.q), 32'(tbl[i].eq));
      chk($sformatf("vec%0d.rd_valid", i), 32'(bus_a.rd_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.err", i), 32'(bus_a.err), 32'(tbl[i].ee));
      chk($sformatf("vec%0d.busy", i), 32'(bus_a.busy), 32'(tbl[i].eb));
    end

    // Test 2: random data at 0x14..0x7F, then read back every written word.
    for (int a = 8'h14; a <= 8'h7F; a++) begin
      d = 9'($urandom);
      cyc(1'b0, 1'b1, 7'(a), d, 1'b0, 7'h00);
    end
    rd_list.push_back(7'h00);
    rd_list.push_back(7'h01);
    for (int a = 8'h14; a <= 8'h7F; a++) rd_list.push_back(7'(a));
    foreach (rd_list[i]) begin
      cyc(1'b0, 1'b0, 7'h00, 9'h000, 1'b1, rd_list[i]);
      $display("read %h: q=%h v=%0d", rd_list[i], bus_a.q, bus_a.rd_valid);
      chk_model($sformatf("rdback%h", rd_list[i]));
    end

    // Test 5: out-of-range accesses on the 100-word instance.
    b_drive(1'b0, 7'h00, 9'h000, 1'b1, 7'h63);
    idle_cyc();
    chk("oor.pre_q", 32'(bus_b.q), 32'h1FF);
    chk("oor.pre_err", 32'(bus_b.err), 32'd0);
    b_drive(1'b1, 7'h70, 9'h155, 1'b0, 7'h00);
    idle_cyc();
    $display("oor write 70: err=%0d", bus_b.err);
    chk("oor.wr_err", 32'(bus_b.err), 32'd1);
    b_drive(1'b0, 7'h00, 9'h000, 1'b1, 7'h70);
    idle_cyc();
    $display("oor read 70: q=%h v=%0d err=%0d", bus_b.q, bus_b.rd_valid, bus_b.err);
    chk("oor.rd_q", 32'(bus_b.q), 32'd0);
    chk("oor.rd_valid", 32'(bus_b.rd_valid), 32'd1);
    chk("oor.rd_err", 32'(bus_b.err), 32'd1);
    b_drive(1'b0, 7'h00, 9'h000, 1'b1, 7'h63);
    idle_cyc();
    chk("oor.post_q", 32'(bus_b.q), 32'h1FF);
    chk("oor.post_err", 32'(bus_b.err), 32'd0);
    b_drive(1'b0, 7'h00, 9'h000, 1'b0, 7'h00);
    idle_cyc();
    chk("oor.idle_err", 32'(bus_b.err), 32'd0);

    // Random traffic including occasional re-initialisation.
    for (int i = 0; i < 400; i++) begin
      wa = 7'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 7'($urandom);
      d  = 9'($urandom);
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), wa, d, 1'($urandom), ra);
      chk_model($sformatf("rnd%0d", i));
    end
    n = 0;
    while (bus_a.busy && n < 300) begin
      idle_cyc();
      n++;
    end
    chk("rnd.settle_busy", 32'(bus_a.busy), 32'd0);

    // Test 4: write while busy is dropped and flagged.
    cyc(1'b1, 1'b0, 7'h00, 9'h000, 1'b0, 7'h00);
    chk("busy.start", 32'(bus_a.busy), 32'd1);
    cyc(1'b0, 1'b1, 7'h10, 9'h0AA, 1'b0, 7'h00);
    $display("write 10 during init: err=%0d busy=%0d", bus_a.err, bus_a.busy);
    chk("busy.err", 32'(bus_a.err), 32'd1);
    chk("busy.busy", 32'(bus_a.busy), 32'd1);
    cyc(1'b1, 1'b0, 7'h00, 9'h000, 1'b1, 7'h10);
    chk("busy.rd_valid", 32'(bus_a.rd_valid), 32'd0);
    n = 2;
    while (bus_a.busy && n < 300) begin
      idle_cyc();
      n++;
    end
    chk("busy.len", 32'(n), 32'd128);
    cyc(1'b0, 1'b0, 7'h00, 9'h000, 1'b1, 7'h10);
    chk("busy.rd10_q", 32'(bus_a.q), 32'h1FF);
    chk("busy.rd10_valid", 32'(bus_a.rd_valid), 32'd1);

    // Test 6: reset in the middle of a sweep.
    cyc(1'b0, 1'b1, 7'h01, 9'h0AB, 1'b1, 7'h01);
    chk("mid.pre_q", 32'(bus_a.q), 32'h0AB);
    cyc(1'b1, 1'b0, 7'h00, 9'h000, 1'b0, 7'h00);
    repeat (50) idle_cyc();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.async_q", 32'(bus_a.q), 32'd0);
    chk("mid.async_busy", 32'(bus_a.busy), 32'd1);
    chk("mid.async_valid", 32'(bus_a.rd_valid), 32'd0);
    chk("mid.async_err", 32'(bus_a.err), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      idle_cyc();
      n++;
      if (!bus_a.busy) break;
    end
    $display("mid-sweep reset: busy low after %0d edges", n);
    chk("mid.len", 32'(n), 32'd128);
    for (int a = 0; a < 128; a++) begin
      cyc(1'b0, 1'b0, 7'h00, 9'h000, 1'b1, 7'(a));
      chk($sformatf("mid.rd%0d_q", a), 32'(bus_a.q), 32'h1FF);
      chk($sformatf("mid.rd%0d_v", a), 32'(bus_a.rd_valid), 32'd1);
    end
    idle_cyc();
    chk("mid.end_valid", 32'(bus_a.rd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
